// File: rtl/mm_arb_pkg.sv
// Shared definitions for the memory-mapped bus arbiter: FSM states,
// timeout return pattern and default parameter values.
package mm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  localparam logic [63:0] TMO_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

  localparam int unsigned NREQ_DEF = 2;
  localparam int unsigned AW_DEF   = 14;
  localparam int unsigned DW_DEF   = 64;
  localparam int unsigned TMO_DEF  = 255;

  // Index width for an N-entry vector, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from the entry after ptr_i,
// wrapping, and returns a one-hot grant plus the winning index.
module rr_arbiter
  import mm_arb_pkg::*;
#(
  parameter int unsigned N = NREQ_DEF
) (
  input  logic [N-1:0]          req_i,
  input  logic [idx_w(N)-1:0]   ptr_i,
  output logic [N-1:0]          gnt_o,
  output logic [idx_w(N)-1:0]   idx_o
);

  localparam int unsigned IW = idx_w(N);

  logic              found;
  logic [31:0]       cand;
  logic [IW-1:0]     cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand     = (32'(ptr_i) + off) % N;
      cand_idx = IW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mm_bus_arbiter.sv
// Arbitrates NREQ memory-mapped requesters onto a single decoder port with
// one outstanding read, a read timeout and sticky error flags.
module mm_bus_arbiter
  import mm_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned TMO  = TMO_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_wr_en,
  input  logic [NREQ-1:0]          req_rd_en,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_wr_data,
  output logic [NREQ-1:0]          req_gnt,
  output logic [DW-1:0]            req_rd_data,
  output logic [NREQ-1:0]          req_rd_data_v,
  output logic                     oMM_WR_EN,
  output logic                     oMM_RD_EN,
  output logic [AW-1:0]            oMM_ADDR,
  output logic [DW-1:0]            oMM_WR_DATA,
  input  logic [DW-1:0]            iMM_RD_DATA,
  input  logic                     iMM_RD_DATA_V,
  output logic                     tmo_err,
  output logic                     proto_err,
  input  logic                     err_clr
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = $clog2(TMO + 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      rd_data_q, rd_data_d;
  logic [NREQ-1:0]    rd_data_v_q, rd_data_v_d;
  logic               tmo_err_q, tmo_err_d;
  logic               proto_err_q, proto_err_d;
  logic               tmo_set, proto_set;
  logic [NREQ-1:0]    gnt_c;

  logic [NREQ-1:0]    active;
  logic [NREQ-1:0]    arb_gnt;
  logic [IW-1:0]      arb_idx;

  assign active = req_wr_en | req_rd_en;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req_i (active),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      rd_data_v_q <= '0;
      tmo_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      rd_data_v_q <= rd_data_v_d;
      tmo_err_q   <= tmo_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next-state, command capture and read-return logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    rd_data_v_d = '0;
    tmo_set     = 1'b0;
    proto_set   = 1'b0;
    gnt_c       = '0;

    case (state_q)
      IDLE: begin
        if (iMM_RD_DATA_V) begin
          proto_set = 1'b1;
        end
        if (|active && !rst) begin
          gnt_c   = arb_gnt;
          ptr_d   = arb_idx;
          owner_d = arb_idx;
          addr_d  = req_addr[arb_idx];
          wdata_d = req_wr_data[arb_idx];
          // A write takes priority over a simultaneous read from one requester.
          if (req_wr_en[arb_idx]) begin
            wr_en_d = 1'b1;
            if (req_rd_en[arb_idx]) begin
              proto_set = 1'b1;
            end
          end else begin
            rd_en_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (iMM_RD_DATA_V) begin
          proto_set = 1'b1;
        end
        if (rd_en_q) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end

      RD_WAIT: begin
        // Valid data in the final wait cycle beats the timeout.
        if (iMM_RD_DATA_V) begin
          rd_data_d            = iMM_RD_DATA;
          rd_data_v_d[owner_q] = 1'b1;
          state_d              = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TMO - 1)) begin
            rd_data_d            = DW'(TMO_DATA);
            rd_data_v_d[owner_q] = 1'b1;
            tmo_set              = 1'b1;
            state_d              = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Sticky flags: a set event overrides a clear in the same cycle.
    tmo_err_d   = tmo_set   ? 1'b1 : (err_clr ? 1'b0 : tmo_err_q);
    proto_err_d = proto_set ? 1'b1 : (err_clr ? 1'b0 : proto_err_q);
  end

  assign req_gnt       = gnt_c;
  assign req_rd_data   = rd_data_q;
  assign req_rd_data_v = rd_data_v_q;
  assign oMM_WR_EN     = wr_en_q;
  assign oMM_RD_EN     = rd_en_q;
  assign oMM_ADDR      = addr_q;
  assign oMM_WR_DATA   = wdata_q;
  assign tmo_err       = tmo_err_q;
  assign proto_err     = proto_err_q;

endmodule

// File: doc/mm_bus_arbiter.md
MM_BUS_ARBITER -- requirements
Module: mm_bus_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- NREQ, 2, number of MM requesters
- AW, 14, address width
- DW, 64, data width
- TMO, 255, read-timeout cycle count
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports are clk and rst. Ports, one per line, name direction width meaning:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_wr_en  in  NREQ  per-requester write request, held until granted
- req_rd_en  in  NREQ  per-requester read request, held until granted
- req_addr  in  NREQ x AW  per-requester address
- req_wr_data  in  NREQ x DW  per-requester write data
- req_gnt  out  NREQ  one-hot accept pulse
- req_rd_data  out  DW  shared read-return data
- req_rd_data_v  out  NREQ  one-hot read-return strobe
- oMM_WR_EN  out  1  write pulse to the address decoder
- oMM_RD_EN  out  1  read pulse to the address decoder
- oMM_ADDR  out  AW  decoder address
- oMM_WR_DATA  out  DW  decoder write data
- iMM_RD_DATA  in  DW  decoder read data
- iMM_RD_DATA_V  in  1  decoder read-data valid
- tmo_err  out  1  sticky read-timeout flag
- proto_err  out  1  sticky protocol-error flag
- err_clr  in  1  clears both sticky flags

Function
REQ-003 SHALL run FSM states IDLE, ISSUE and RD_WAIT.
REQ-004 IDLE: a requester is active when req_wr_en or req_rd_en is high; with any active requester, SHALL pick a winner round-robin, pulse req_gnt[winner] combinationally in the same cycle, register the winner's command, and go to ISSUE.
REQ-005 Round-robin SHALL search starting at the requester after the last granted one, wrapping from NREQ-1 to 0; the pointer SHALL update only on grant.
REQ-006 ISSUE: SHALL drive exactly one cycle of oMM_WR_EN or oMM_RD_EN with the registered oMM_ADDR/oMM_WR_DATA, and SHALL ignore all requests.
- write: next state IDLE (max one write per 2 cycles).
- read: next state RD_WAIT, owner = winner, timeout counter = 0.
REQ-007 oMM_ADDR/oMM_WR_DATA SHALL hold their last value outside ISSUE; the enables SHALL be 0 outside ISSUE.
REQ-008 RD_WAIT: on iMM_RD_DATA_V, SHALL register iMM_RD_DATA onto req_rd_data and pulse req_rd_data_v[owner] one cycle later, then go to IDLE; only one read SHALL be outstanding.
REQ-009 RD_WAIT: the counter SHALL increment each cycle. When it reaches TMO with no valid, SHALL:
- return 64'hDEAD_DEAD_DEAD_DEAD to the owner with the same one-cycle strobe;
- set tmo_err;
- go to IDLE.
REQ-010 iMM_RD_DATA_V outside RD_WAIT SHALL be dropped and SHALL set proto_err.
REQ-011 When a requester asserts wr_en and rd_en together, the write SHALL win and proto_err SHALL be set.
REQ-012 If err_clr and a set event occur in the same cycle, the set SHALL win.
REQ-013 In the TMO-th wait cycle, a valid SHALL beat the timeout: real data returned, tmo_err not set.

Reset
REQ-014 On rst, all outputs SHALL be 0, state IDLE, the RR pointer SHALL be NREQ-1 so requester 0 wins first, and the counter SHALL be 0.
REQ-015 Reset mid-read SHALL abandon the read with no req_rd_data_v; late decoder data after reset SHALL set proto_err.

Structure
REQ-016 Shared package mm_arb_pkg SHALL hold the state enum, the TMO_DATA constant (64'hDEAD_DEAD_DEAD_DEAD) and the default parameter values.
REQ-017 The round-robin picker SHALL be sub-module rr_arbiter (req vector and pointer in, one-hot grant and index out, purely combinational).

Verification
REQ-018 Directed scenarios a bench SHALL cover:
- req 0 and 1 both write at once, addrs 0x010/0x020 -> gnt0 cycle N; oMM_WR_EN with addr 0x010 at N+1; gnt1 at N+2; addr 0x020 at N+3.
- req 1 reads 0x005, decoder valid 3 cycles after oMM_RD_EN with 0x1234 -> req_rd_data_v[1] with 0x1234 one cycle after valid; req 0 is not granted during RD_WAIT.
- read, decoder silent -> after 255 wait cycles req_rd_data=DEAD_DEAD_DEAD_DEAD to the owner, tmo_err=1; err_clr -> 0.
- valid in the 255th wait cycle -> real data returned, tmo_err stays 0.
- stray iMM_RD_DATA_V in IDLE -> no strobe, proto_err=1; rst during RD_WAIT -> all outputs 0, next grant goes to req 0.
